// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and constants for the async-FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_NREQ     = 32'd4;
  localparam int unsigned DEF_DATASIZE = 32'd8;
  localparam int unsigned DEF_MAXBEATS = 32'd16;

  // Index width for n entries; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-side bundle of the write arbiter; master is the arbiter, slave the environment.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ     = DEF_NREQ,
  parameter int unsigned DATASIZE = DEF_DATASIZE
);

  logic [NREQ-1:0]          req_valid;
  logic [NREQ*DATASIZE-1:0] req_data;
  logic [NREQ-1:0]          req_last;
  logic [NREQ-1:0]          req_ready;
  logic                     fifo_wfull;
  logic                     fifo_winc;
  logic [DATASIZE-1:0]      fifo_wdata;
  logic [idx_w(NREQ)-1:0]   grant_id;
  logic                     busy;
  logic                     ovr_err;

  modport master (
    input  req_valid, req_data, req_last, fifo_wfull,
    output req_ready, fifo_winc, fifo_wdata, grant_id, busy, ovr_err
  );

  modport slave (
    output req_valid, req_data, req_last, fifo_wfull,
    input  req_ready, fifo_winc, fifo_wdata, grant_id, busy, ovr_err
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_start, wrapping modulo NREQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_start,
  output logic            o_found,
  output logic [IW-1:0]   o_idx
);

  // Wrap with a modulo so non-power-of-2 NREQ never selects a phantom index.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (!o_found && i_req[(int'(i_start) + k) % int'(NREQ)]) begin
        o_found = 1'b1;
        o_idx   = IW'((int'(i_start) + k) % int'(NREQ));
      end else begin
        o_found = o_found;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing one async-FIFO write port among NREQ requesters.
// A per-grant beat limit forces release so a requester that never sends last cannot starve others.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ     = DEF_NREQ,
  parameter int unsigned DATASIZE = DEF_DATASIZE,
  parameter int unsigned MAXBEATS = DEF_MAXBEATS
) (
  input  logic              wclk,
  input  logic              wrst_n,
  fifo_wr_arbiter_if.master bus
);

  localparam int unsigned IW = idx_w(NREQ);
  localparam int unsigned CW = idx_w(MAXBEATS + 32'd1);

  arb_state_e    r_state;
  arb_state_e    w_next_state;
  logic [IW-1:0] r_rr_ptr;
  logic [IW-1:0] r_grant_id;
  logic [CW-1:0] r_beat_cnt;
  logic          r_ovr_err;
  logic          w_found;
  logic [IW-1:0] w_pick_idx;
  logic          w_accept;
  logic          w_last;
  logic          w_at_limit;
  logic          w_force;
  logic          w_release;
  logic [IW-1:0] w_ptr_next;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .i_req   (bus.req_valid),
    .i_start (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_pick_idx)
  );

  // wfull is already registered in wclk, so gating on it adds no loop through winc.
  assign w_accept   = (r_state == GRANT) & bus.req_valid[r_grant_id] & ~bus.fifo_wfull;
  assign w_last     = bus.req_last[r_grant_id];
  assign w_at_limit = (r_beat_cnt == CW'(MAXBEATS - 32'd1));
  assign w_force    = w_accept & ~w_last & w_at_limit;
  assign w_release  = w_accept & (w_last | w_at_limit);
  assign w_ptr_next = (r_grant_id == IW'(NREQ - 32'd1)) ? '0 : r_grant_id + IW'(1);

  // State register; reset drops any in-flight packet straight back to IDLE.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    w_next_state = w_found ? GRANT : IDLE;
      GRANT:   w_next_state = w_release ? IDLE : GRANT;
      default: w_next_state = IDLE;
    endcase
  end

  // Grant bookkeeping: winner index, beat count, round-robin pointer, overrun pulse.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
      r_ovr_err  <= 1'b0;
    end else begin
      r_ovr_err <= w_force;
      if ((r_state == IDLE) && w_found) begin
        r_grant_id <= w_pick_idx;
        r_beat_cnt <= '0;
      end else if (w_accept) begin
        r_beat_cnt <= r_beat_cnt + CW'(1);
      end else begin
        r_beat_cnt <= r_beat_cnt;
      end
      if (w_release) begin
        r_rr_ptr <= w_ptr_next;
      end else begin
        r_rr_ptr <= r_rr_ptr;
      end
    end
  end

  // Write strobe, ready and data follow registered state and live inputs.
  always_comb begin
    bus.req_ready             = '0;
    bus.req_ready[r_grant_id] = w_accept;
    bus.fifo_winc             = w_accept;
    bus.fifo_wdata            = bus.req_data[int'(r_grant_id) * int'(DATASIZE) +: DATASIZE];
    bus.grant_id              = r_grant_id;
    bus.busy                  = (r_state == GRANT);
    bus.ovr_err               = r_ovr_err;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin, packet-locked arbiter that shares the single write port of the asynchronous FIFO between NREQ requesters in the write clock domain. It drives the FIFO's write-increment and write-data inputs and gates acceptance on the FIFO's write-full flag. A per-packet beat limit guarantees forward progress if a requester never asserts last.

## Interface
- NREQ, 4: number of requesters, 2..16.
- DATASIZE, 8: data width; equals the FIFO data width.
- MAXBEATS, 16: maximum accepted beats per grant before forced release, ≥1.
- wclk  in  1  write clock; all logic on rising edge.
- wrst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester beat valid.
- req_data  in  NREQ*DATASIZE  requester i occupies bits [i*DATASIZE +: DATASIZE].
- req_last  in  NREQ  beat is the final beat of its packet.
- req_ready  out  NREQ  beat accepted this cycle; one-hot or zero.
- fifo_wfull  in  1  FIFO write-full flag, registered in the wclk domain.
- fifo_winc  out  1  write strobe to the FIFO.
- fifo_wdata  out  DATASIZE  write data to the FIFO.
- grant_id  out  $clog2(NREQ)  index of the current or last granted requester.
- busy  out  1  FSM in GRANT.
- ovr_err  out  1  one-cycle pulse on forced release.

## Operation
- FSM states: IDLE, GRANT.
- IDLE: if any req_valid, pick the first valid index at or after rr_ptr, wrapping modulo NREQ. Load grant_id, clear beat_cnt, go to GRANT. Otherwise stay.
- GRANT: accept = req_valid[grant_id] & ~fifo_wfull.
  - fifo_winc = accept.
  - req_ready[grant_id] = accept; all other ready bits are 0.
  - fifo_wdata = the granted slice, unconditionally.
- On each accept, beat_cnt increments.
- Normal release: accept with req_last[grant_id] → IDLE next cycle, rr_ptr = grant_id+1 mod NREQ.
- Forced release: accept without last when beat_cnt == MAXBEATS-1 → IDLE, ovr_err pulses next cycle, rr_ptr advances as for normal release. The requester's remaining beats form a new packet at its next grant.
- Granted requester deasserting valid mid-packet: the grant holds, no write occurs, and beat_cnt is unchanged.
- Requesters must hold valid and data stable until ready. Non-granted requesters are never dropped.
- fifo_wfull high: no accept, state and beat_cnt hold, and the lock persists. The FIFO never sees winc while full.
- beat_cnt width is $clog2(MAXBEATS+1). rr_ptr and grant_id wrap modulo NREQ; this matters when NREQ is not a power of 2.

## Timing
- Reset values: state IDLE, rr_ptr 0, grant_id 0, beat_cnt 0, busy 0, ovr_err 0. fifo_winc and req_ready are 0 while in reset and combinationally follow state afterwards.
- Latency: valid in IDLE at edge k → grant registered at k → first accept possible in cycle k+1.
- Throughput: one beat per cycle while the FIFO is not full. There is one IDLE bubble between packets, so a P-beat packet occupies P+1 cycles minimum.
- fifo_winc, req_ready, and fifo_wdata are combinational from registered state and inputs. There is no combinational path from fifo_winc back to fifo_wfull.
- Reset asserted mid-packet returns the block to IDLE immediately. Beats already written stay in the FIFO; the partial packet is not recovered.
- Simultaneous requests in IDLE: round-robin order starting from rr_ptr. A requester newly valid during GRANT waits for release.

## Structure
- Package fifo_arb_pkg: state enum {IDLE, GRANT}, an index-width function (clog2, minimum 1), and default parameter constants.
- Sub-module rr_pick: combinational priority picker with inputs req vector and start pointer, outputs found and index. fifo_wr_arbiter instantiates it once.

## Test plan
- Single requester 0 sends 3 beats 0x11,0x22,0x33 (last on 0x33), FIFO not full → fifo_winc high for 3 consecutive cycles starting one cycle after valid, with data in order. busy falls one cycle after the last accept.
- All 4 requesters valid with 1-beat packets, rr_ptr=0 → grants in order 0,1,2,3,0. Each packet takes 2 cycles.
- Requester 2 mid-packet while fifo_wfull is held high for 5 cycles → no fifo_winc and no req_ready during those cycles. The grant stays 2, and the remaining beats resume on the first cycle wfull is low.
- Requester 1 streams 20 beats with no last, MAXBEATS=16 → exactly 16 writes, then ovr_err pulses once. A waiting requester 2 is granted next.
- Granted requester drops valid for 3 cycles mid-packet while others are valid → the grant holds, no writes occur, and the packet completes intact.
- wrst_n asserted after the 2nd of 4 beats → busy, fifo_winc, and req_ready go to 0 at once. After reset release, arbitration restarts from requester 0.
